// File: rtl/prime_fifo.sv
// prime_fifo -- sequencer and output buffer downstream of primegen.
//
// Issues one generation request at a time to primegen, captures each
// completed prime into a DEPTH-entry circular FIFO, and presents the FIFO
// head on a valid/ready stream. Generator error and numeric wrap-around
// (a result not larger than the previous one) halt the sequencer; the FIFO
// keeps draining after a halt.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset, shared with primegen
//   enable     allows new generation requests (sampled in IDLE only)
//   gen_go     request pulse to primegen.go
//   gen_ready  primegen.ready
//   gen_error  primegen.error
//   gen_res    primegen.res
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts head entry
//   out_data   FIFO head entry
//   level      FIFO occupancy, 0..DEPTH
//   error      sticky: generator reported an error
//   done       sticky: generator output wrapped
module prime_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             gen_go,
  input  logic             gen_ready,
  input  logic             gen_error,
  input  logic [WIDTH-1:0] gen_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW:0]      level,
  output logic             error,
  output logic             done
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    HALT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] last;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             capture;
  logic             push;
  logic             pop;

  // A result is accepted only when it is error-free and strictly larger
  // than the previous one; anything else means the generator wrapped.
  assign capture = (state == WAIT_DONE) && gen_ready;
  assign push    = capture && !gen_error && (gen_res > last);
  assign pop     = out_valid && out_ready;

  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];

  // Sequencer. gen_go is registered together with the ISSUE transition so
  // it is high for exactly the cycle spent in ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gen_go <= 1'b0;
      error  <= 1'b0;
      done   <= 1'b0;
      last   <= WIDTH'(1);
    end else begin
      gen_go <= 1'b0;
      case (state)
        IDLE: begin
          // Only admit a request when a slot is free, so a capture never
          // meets a full FIFO.
          if (enable && gen_ready && (level < FULL)) begin
            state  <= ISSUE;
            gen_go <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!gen_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (gen_ready) begin
            if (gen_error) begin
              error <= 1'b1;
              state <= HALT;
            end else if (gen_res <= last) begin
              done  <= 1'b1;
              state <= HALT;
            end else begin
              last  <= gen_res;
              state <= IDLE;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage. Entry 0 is cleared so out_data reads 0 straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= gen_res;
    end
  end

endmodule

// File: tb/tb_prime_fifo.sv
module tb_prime_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        gen_go;
  logic        gen_ready;
  logic        gen_error;
  logic [15:0] gen_res;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  level;
  logic        error;
  logic        done;

  int errors = 0;
  int checks = 0;

  // Response table for the behavioural generator and the request index at
  // which it reports an error (-1: never).
  int resp [0:31];
  int primes [0:31];
  int err_at = -1;

  always #5 clk = ~clk;

  prime_fifo #(.WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .gen_go(gen_go), .gen_ready(gen_ready), .gen_error(gen_error), .gen_res(gen_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .error(error), .done(done)
  );

  // Behavioural primegen: ready=1, res=1 after reset; on a sampled go rising
  // edge drops ready, then after a few cycles raises ready with the next
  // table entry (or with error on request err_at).
  logic        m_ready, m_err, go_d;
  logic [15:0] m_res;
  int          m_cnt, m_req;

  always @(posedge clk) begin
    if (rst) begin
      m_ready <= 1'b1;
      m_res   <= 16'd1;
      m_err   <= 1'b0;
      go_d    <= 1'b0;
      m_cnt   <= 0;
      m_req   <= 0;
    end else begin
      go_d <= gen_go;
      if (gen_go && !go_d && m_ready) begin
        m_ready <= 1'b0;
        m_cnt   <= 3;
      end else if (!m_ready) begin
        if (m_cnt == 0) begin
          m_ready <= 1'b1;
          if (m_req == err_at) m_err <= 1'b1;
          else m_res <= 16'(resp[m_req]);
          m_req <= m_req + 1;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  assign gen_ready = m_ready;
  assign gen_error = m_err;
  assign gen_res   = m_res;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    enable = 1'b0;
    out_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Holds until the head entry is popped (caller keeps out_ready high).
  task automatic wait_pop(output logic [15:0] v, output bit to);
    bit got;
    got = 1'b0;
    to  = 1'b1;
    v   = '0;
    for (int i = 0; i < 500 && !got; i++) begin
      if (out_valid && out_ready) begin
        v   = out_data;
        to  = 1'b0;
        got = 1'b1;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;
    tick;
    tick;
    checks++; if (gen_go !== 1'b0)     begin errors++; $display("FAIL reset_gen_go got=%b want=0", gen_go); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 16'd0)  begin errors++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
    checks++; if (level !== 4'd0)      begin errors++; $display("FAIL reset_level got=%0d want=0", level); end
    checks++; if (error !== 1'b0)      begin errors++; $display("FAIL reset_error got=%b want=0", error); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    rst = 1'b0;
    enable = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_basic_stream;
    logic [15:0] v;
    bit to;
    do_reset;
    enable = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_pop(v, to);
      checks++;
      if (to) begin errors++; $display("FAIL basic_pop%0d timeout", k); end
      else if (v !== 16'(primes[k])) begin errors++; $display("FAIL basic_pop%0d got=%0d want=%0d", k, v, primes[k]); end
    end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error got=%b want=0", error); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL basic_done got=%b want=0", done); end
  endtask

  task automatic test_full;
    logic [15:0] v;
    bit to;
    int n;
    int gocnt;
    do_reset;
    enable = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (level !== 4'd8 && n < 1000) begin tick; n++; end
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_fill got level=%0d want=8", level); end
    checks++; if (out_data !== 16'd2) begin errors++; $display("FAIL full_head got=%0d want=2", out_data); end
    gocnt = 0;
    for (int i = 0; i < 200; i++) begin if (gen_go) gocnt++; tick; end
    checks++; if (gocnt != 0) begin errors++; $display("FAIL full_hold gen_go cycles=%0d want=0", gocnt); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    checks++; if (level !== 4'd7) begin errors++; $display("FAIL full_pop level=%0d want=7", level); end
    gocnt = 0;
    for (int i = 0; i < 60; i++) begin if (gen_go) gocnt++; tick; end
    checks++; if (gocnt != 1) begin errors++; $display("FAIL full_reissue gen_go cycles=%0d want=1", gocnt); end
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_refill level=%0d want=8", level); end
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      wait_pop(v, to);
      checks++;
      if (to) begin errors++; $display("FAIL full_drain%0d timeout", k); end
      else if (v !== 16'(primes[k])) begin errors++; $display("FAIL full_drain%0d got=%0d want=%0d", k, v, primes[k]); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int n;
    do_reset;
    enable = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      n = 0;
      while (gen_ready !== 1'b0 && n < 200) begin tick; n++; end
      n = 0;
      while (gen_ready !== 1'b1 && n < 200) begin tick; n++; end
      checks++;
      if (gen_ready !== 1'b1) begin errors++; $display("FAIL simul_req%0d timeout", k); end
      // The capture happens at the next edge; pop the previous entry then.
      if (k > 0) begin
        checks++;
        if (out_data !== 16'(primes[k-1])) begin errors++; $display("FAIL simul_head%0d got=%0d want=%0d", k, out_data, primes[k-1]); end
        out_ready = 1'b1;
      end
      tick;
      out_ready = 1'b0;
      checks++;
      if (level !== 4'd1) begin errors++; $display("FAIL simul_level%0d got=%0d want=1", k, level); end
    end
    checks++; if (out_data !== 16'd71) begin errors++; $display("FAIL simul_last got=%0d want=71", out_data); end
  endtask

  task automatic test_error;
    logic [15:0] v;
    bit to;
    int n;
    int gocnt;
    err_at = 2;
    do_reset;
    enable = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (gen_error !== 1'b1 && n < 500) begin tick; n++; end
    checks++; if (gen_error !== 1'b1) begin errors++; $display("FAIL err_model timeout"); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_early got=%b want=0", error); end
    tick;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_flag got=%b want=1", error); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL err_done got=%b want=0", done); end
    checks++; if (level !== 4'd2) begin errors++; $display("FAIL err_level got=%0d want=2", level); end
    gocnt = 0;
    for (int i = 0; i < 100; i++) begin if (gen_go) gocnt++; tick; end
    checks++; if (gocnt != 0) begin errors++; $display("FAIL err_halt gen_go cycles=%0d want=0", gocnt); end
    out_ready = 1'b1;
    wait_pop(v, to);
    checks++; if (to || v !== 16'd2) begin errors++; $display("FAIL err_drain0 got=%0d want=2 timeout=%0b", v, to); end
    wait_pop(v, to);
    checks++; if (to || v !== 16'd3) begin errors++; $display("FAIL err_drain1 got=%0d want=3 timeout=%0b", v, to); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL err_empty level=%0d want=0", level); end
    out_ready = 1'b0;
    err_at = -1;
  endtask

  task automatic test_wrap;
    logic [15:0] q [$];
    int n;
    int gocnt;
    resp[10] = 3;
    do_reset;
    enable = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (!(done === 1'b1 && level === 4'd0) && n < 2000) begin
      if (out_valid && out_ready) q.push_back(out_data);
      tick;
      n++;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done got=%b want=1", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL wrap_error got=%b want=0", error); end
    checks++; if (q.size() != 10) begin errors++; $display("FAIL wrap_count got=%0d want=10", q.size()); end
    if (q.size() == 10) begin
      checks++; if (q[9] !== 16'd29) begin errors++; $display("FAIL wrap_last got=%0d want=29", q[9]); end
      checks++; if (q[0] !== 16'd2) begin errors++; $display("FAIL wrap_first got=%0d want=2", q[0]); end
    end
    gocnt = 0;
    for (int i = 0; i < 50; i++) begin if (gen_go) gocnt++; tick; end
    checks++; if (gocnt != 0) begin errors++; $display("FAIL wrap_halt gen_go cycles=%0d want=0", gocnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_no3 out_valid=%b want=0", out_valid); end
    resp[10] = primes[10];
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [15:0] v;
    bit to;
    int n;
    do_reset;
    enable = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (level !== 4'd5 && n < 1000) begin tick; n++; end
    n = 0;
    while (gen_ready !== 1'b0 && n < 200) begin tick; n++; end
    tick;
    checks++; if (level !== 4'd5 || gen_ready !== 1'b0) begin errors++; $display("FAIL rmid_setup level=%0d ready=%b want 5/0", level, gen_ready); end
    rst = 1'b1;
    tick;
    checks++; if (level !== 4'd0)     begin errors++; $display("FAIL rmid_level got=%0d want=0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b want=0", out_valid); end
    checks++; if (error !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rmid_flags error=%b done=%b want 0/0", error, done); end
    checks++; if (gen_go !== 1'b0)    begin errors++; $display("FAIL rmid_gen_go got=%b want=0", gen_go); end
    rst = 1'b0;
    out_ready = 1'b1;
    wait_pop(v, to);
    checks++; if (to || v !== 16'd2) begin errors++; $display("FAIL rmid_restart got=%0d want=2 timeout=%0b", v, to); end
    out_ready = 1'b0;
  endtask

  initial begin
    primes = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53,
               59, 61, 67, 71, 73, 79, 83, 89, 97, 101, 103, 107, 109, 113, 127, 131};
    resp = primes;
    rst = 1'b1;
    enable = 1'b0;
    out_ready = 1'b0;
    test_reset;
    test_basic_stream;
    test_full;
    test_back_to_back;
    test_error;
    test_wrap;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
